// File: rtl/uart_dbg_pkg.sv
// Shared constants and FSM state set for the uart debug command sequencer.
// UART_DBG_CSUM_EN adds the frame/response checksum states.
package uart_dbg_pkg;

  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef UART_DBG_CSUM_EN
    S_GET_CSUM,
    S_TX_CSUM,
    S_TX_CSUM_WAIT,
`endif
    S_GET_ADDR,
    S_GET_DATA,
    S_BUS_REQ,
    S_BUS_WAIT,
    S_TX_STAT,
    S_TX_STAT_WAIT,
    S_TX_DATA,
    S_TX_DATA_WAIT
  } state_e;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WR) || (b == OP_RD);
  endfunction

endpackage

// File: rtl/uart_dbg_cmd_ctrl_if.sv
// Uart-core byte handshake and internal register-bus interfaces.
// The command sequencer is the master on both.
interface uart_dbg_uart_if;
  logic [7:0] rx_byte;
  logic       received;
  logic       is_transmitting;
  logic [7:0] tx_byte;
  logic       transmit;

  modport master (input rx_byte, received, is_transmitting, output tx_byte, transmit);
  modport slave  (output rx_byte, received, is_transmitting, input tx_byte, transmit);
endinterface

interface uart_dbg_reg_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              reg_ack;

  modport master (output reg_addr, reg_wdata, reg_we, reg_re, input reg_rdata, reg_ack);
  modport slave  (input reg_addr, reg_wdata, reg_we, reg_re, output reg_rdata, reg_ack);
endinterface

// File: rtl/uart_dbg_tx_seq.sv
// One-byte uart transmit handshake: strobe when the uart is free, then
// report completion once it has gone busy and come back idle.
module uart_dbg_tx_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_i,
  input  logic       chk_i,
  input  logic [7:0] byte_i,
  input  logic       busy_i,
  output logic       fire_o,
  output logic       done_o,
  output logic       transmit_o,
  output logic [7:0] tx_byte_o
);

  logic       transmit_q;
  logic [7:0] tx_byte_q;
  logic       skip_q;

  assign fire_o = send_i & ~busy_i;
  // The uart only raises its busy flag after seeing the strobe, so the
  // strobe cycle itself must not be read as "already finished".
  assign done_o = chk_i & ~skip_q & ~busy_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      transmit_q <= 1'b0;
      tx_byte_q  <= '0;
      skip_q     <= 1'b0;
    end else begin
      transmit_q <= fire_o;
      skip_q     <= fire_o;
      if (fire_o) tx_byte_q <= byte_i;
    end
  end

  assign transmit_o = transmit_q;
  assign tx_byte_o  = tx_byte_q;

endmodule

// File: rtl/uart_dbg_cmd_ctrl.sv
// Parses uart command frames into single register-bus accesses and returns
// ACK/NAK (+ read data). UART_DBG_CSUM_EN enables frame/response checksums.
module uart_dbg_cmd_ctrl
  import uart_dbg_pkg::*;
#(
  parameter int CLK_FREQ         = 12000000,
  parameter int BYTE_TIMEOUT_CYC = CLK_FREQ / 100,
  parameter int BUS_TIMEOUT_CYC  = 255,
  parameter int ADDR_W           = 8
) (
  input  logic             iCE_CLK,
  input  logic             rst_n,
  uart_dbg_uart_if.master  uart,
  uart_dbg_reg_if.master   regb,
  output logic             busy,
  output logic             err
);

  localparam int TMR_MAX = (BYTE_TIMEOUT_CYC > BUS_TIMEOUT_CYC) ? BYTE_TIMEOUT_CYC : BUS_TIMEOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] BYTE_TO = TMR_W'(BYTE_TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] BUS_TO  = TMR_W'(BUS_TIMEOUT_CYC);

  state_e            state_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q, rdata_q, stat_q;
  logic [TMR_W-1:0]  tmr_q;
  logic              we_q, re_q, err_q;
`ifdef UART_DBG_CSUM_EN
  logic [7:0]        csum_q;
`endif

  logic       tx_send, tx_chk, tx_fire, tx_done;
  logic [7:0] tx_val;

  always_comb begin
    tx_send = 1'b0;
    tx_chk  = 1'b0;
    tx_val  = stat_q;
    case (state_q)
      S_TX_STAT:      tx_send = 1'b1;
      S_TX_STAT_WAIT: tx_chk  = 1'b1;
      S_TX_DATA:      begin tx_send = 1'b1; tx_val = rdata_q; end
      S_TX_DATA_WAIT: tx_chk  = 1'b1;
`ifdef UART_DBG_CSUM_EN
      S_TX_CSUM:      begin tx_send = 1'b1; tx_val = 8'(ACK + rdata_q); end
      S_TX_CSUM_WAIT: tx_chk  = 1'b1;
`endif
      default: ;
    endcase
  end

  uart_dbg_tx_seq u_tx (
    .clk       (iCE_CLK),
    .rst_n     (rst_n),
    .send_i    (tx_send),
    .chk_i     (tx_chk),
    .byte_i    (tx_val),
    .busy_i    (uart.is_transmitting),
    .fire_o    (tx_fire),
    .done_o    (tx_done),
    .transmit_o(uart.transmit),
    .tx_byte_o (uart.tx_byte)
  );

  always_ff @(posedge iCE_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      stat_q  <= '0;
      tmr_q   <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_DBG_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      we_q  <= 1'b0;
      re_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tmr_q <= '0;
          if (uart.received) begin
            if (is_opcode(uart.rx_byte)) begin
              rd_q    <= (uart.rx_byte == OP_RD);
              state_q <= S_GET_ADDR;
`ifdef UART_DBG_CSUM_EN
              csum_q  <= uart.rx_byte;
`endif
            end else begin
              stat_q  <= NAK;
              err_q   <= 1'b1;
              state_q <= S_TX_STAT;
            end
          end
        end
        S_GET_ADDR: begin
          if (uart.received) begin
            addr_q <= uart.rx_byte[ADDR_W-1:0];
            tmr_q  <= '0;
`ifdef UART_DBG_CSUM_EN
            csum_q <= csum_q + uart.rx_byte;
            state_q <= rd_q ? S_GET_CSUM : S_GET_DATA;
`else
            state_q <= rd_q ? S_BUS_REQ : S_GET_DATA;
            re_q    <= rd_q;
`endif
          end else if (tmr_q == BYTE_TO) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        S_GET_DATA: begin
          if (uart.received) begin
            wdata_q <= uart.rx_byte;
            tmr_q   <= '0;
`ifdef UART_DBG_CSUM_EN
            csum_q  <= csum_q + uart.rx_byte;
            state_q <= S_GET_CSUM;
`else
            state_q <= S_BUS_REQ;
            we_q    <= 1'b1;
`endif
          end else if (tmr_q == BYTE_TO) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
`ifdef UART_DBG_CSUM_EN
        S_GET_CSUM: begin
          if (uart.received) begin
            tmr_q <= '0;
            if (uart.rx_byte == csum_q) begin
              we_q    <= ~rd_q;
              re_q    <= rd_q;
              state_q <= S_BUS_REQ;
            end else begin
              stat_q  <= NAK;
              err_q   <= 1'b1;
              state_q <= S_TX_STAT;
            end
          end else if (tmr_q == BYTE_TO) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
`endif
        S_BUS_REQ: begin
          tmr_q   <= '0;
          state_q <= S_BUS_WAIT;
        end
        S_BUS_WAIT: begin
          // An ack landing on the timeout cycle still wins.
          if (regb.reg_ack) begin
            rdata_q <= regb.reg_rdata;
            stat_q  <= ACK;
            state_q <= S_TX_STAT;
          end else if (tmr_q == BUS_TO) begin
            stat_q  <= NAK;
            err_q   <= 1'b1;
            state_q <= S_TX_STAT;
          end else begin
            tmr_q <= tmr_q + TMR_W'(1);
          end
        end
        S_TX_STAT:      if (tx_fire) state_q <= S_TX_STAT_WAIT;
        S_TX_STAT_WAIT: if (tx_done) state_q <= (stat_q == ACK && rd_q) ? S_TX_DATA : S_IDLE;
        S_TX_DATA:      if (tx_fire) state_q <= S_TX_DATA_WAIT;
`ifdef UART_DBG_CSUM_EN
        S_TX_DATA_WAIT: if (tx_done) state_q <= S_TX_CSUM;
        S_TX_CSUM:      if (tx_fire) state_q <= S_TX_CSUM_WAIT;
        S_TX_CSUM_WAIT: if (tx_done) state_q <= S_IDLE;
`else
        S_TX_DATA_WAIT: if (tx_done) state_q <= S_IDLE;
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign regb.reg_addr  = addr_q;
  assign regb.reg_wdata = wdata_q;
  assign regb.reg_we    = we_q;
  assign regb.reg_re    = re_q;
  assign busy           = (state_q != S_IDLE);
  assign err            = err_q;

endmodule

// File: tb/tb_uart_dbg_cmd_ctrl.sv
// Bench for uart_dbg_cmd_ctrl: uart-core and register-slave models plus a
// frame-level reference model predicting response bytes, bus ops and errors.
module tb_uart_dbg_cmd_ctrl;

  localparam int BYTE_TO = 1000;
  localparam int BUS_TO  = 255;
  localparam int TXLEN   = 20;
  localparam logic [7:0] M_ACK = 8'h06, M_NAK = 8'h15, M_WR = 8'h57, M_RD = 8'h52;

  typedef struct { bit we; logic [7:0] addr; logic [7:0] data; } op_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic busy, err;
  always #5 clk = ~clk;

  uart_dbg_uart_if u();
  uart_dbg_reg_if #(.ADDR_W(8)) r();

  uart_dbg_cmd_ctrl #(.CLK_FREQ(12000000), .BYTE_TIMEOUT_CYC(BYTE_TO),
                      .BUS_TIMEOUT_CYC(BUS_TO), .ADDR_W(8)) dut (
    .iCE_CLK(clk), .rst_n(rst_n), .uart(u), .regb(r), .busy(busy), .err(err));

  int checks = 0, errors = 0;
  int cyc = 0, errs = 0;
  logic [7:0] tx_q[$];
  op_t ops_q[$];
  int tx_cyc_last = 0, req_cyc = 0, ack_cyc = 0, min_lat = 1000;
  bit lat_arm = 0;
  int viol_tx = 0, viol_bus = 0;
  int ack_dly = 1;
  logic [7:0] rd_val = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  // uart core: busy for TXLEN cycles after each strobe
  initial begin
    int bcnt;
    bit was;
    bcnt = 0;
    u.is_transmitting = 1'b0;
    forever begin
      @(negedge clk);
      was = u.is_transmitting;
      if (bcnt > 0) begin bcnt--; if (bcnt == 0) u.is_transmitting = 1'b0; end
      if (u.transmit === 1'b1) begin
        if (was) viol_tx++;
        tx_q.push_back(u.tx_byte);
        tx_cyc_last = cyc;
        if (lat_arm) begin
          if (cyc - ack_cyc < min_lat) min_lat = cyc - ack_cyc;
          lat_arm = 0;
        end
        u.is_transmitting = 1'b1;
        bcnt = TXLEN;
      end
    end
  end

  // register slave: ack after ack_dly cycles, never when ack_dly == 0
  initial begin
    int cnt;
    bit pend;
    op_t cur;
    pend = 0; cnt = 0;
    cur.we = 0; cur.addr = 0; cur.data = 0;
    r.reg_ack = 1'b0;
    r.reg_rdata = 8'h00;
    forever begin
      @(negedge clk);
      r.reg_ack = 1'b0;
      if (pend) begin
        if (r.reg_addr !== cur.addr || (cur.we && r.reg_wdata !== cur.data)) viol_bus++;
        if (cnt == 1) begin
          r.reg_ack = 1'b1; r.reg_rdata = rd_val; pend = 0;
          ack_cyc = cyc; lat_arm = 1;
        end else cnt--;
      end
      if (r.reg_we === 1'b1 || r.reg_re === 1'b1) begin
        cur.we = r.reg_we; cur.addr = r.reg_addr; cur.data = r.reg_wdata;
        ops_q.push_back(cur);
        req_cyc = cyc;
        if (ack_dly > 0) begin pend = 1; cnt = ack_dly; end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (err === 1'b1) errs++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    u.rx_byte = b; u.received = 1'b1;
    @(negedge clk);
    u.received = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < lim) begin @(negedge clk); n++; end
    chk({tag, "_idle"}, 32'(busy), 32'(0));
    repeat (2) @(negedge clk);
  endtask

  // Reference model: predict the whole response of one frame, then compare.
  task automatic run_frame(input logic [7:0] op, input logic [7:0] addr, input logic [7:0] data,
                           input int dly, input logic [7:0] rdv, input string tag);
    logic [7:0] exp[$];
    logic [7:0] sum;
    bit exp_op, exp_we;
    int exp_err, e0;
    tx_q.delete(); ops_q.delete();
    e0 = errs; ack_dly = dly; rd_val = rdv;
    exp_op = (op == M_WR) || (op == M_RD);
    exp_we = (op == M_WR);
    if (!exp_op || dly == 0) begin
      exp = {M_NAK}; exp_err = 1;
    end else begin
      exp = {M_ACK}; exp_err = 0;
      if (!exp_we) begin
        exp.push_back(rdv);
`ifdef UART_DBG_CSUM_EN
        exp.push_back(8'(M_ACK + rdv));
`endif
      end
    end
    send_byte(op);
    if (exp_op) begin
      send_byte(addr);
      sum = 8'(op + addr);
      if (exp_we) begin send_byte(data); sum = 8'(sum + data); end
`ifdef UART_DBG_CSUM_EN
      send_byte(sum);
`endif
    end
    wait_idle(tag, 3000);
    chk({tag, "_ntx"}, 32'(tx_q.size()), 32'(exp.size()));
    foreach (exp[i]) if (i < tx_q.size()) chk($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(exp[i]));
    chk({tag, "_nops"}, 32'(ops_q.size()), 32'(exp_op));
    if (exp_op && ops_q.size() > 0) begin
      chk({tag, "_we"}, 32'(ops_q[0].we), 32'(exp_we));
      chk({tag, "_addr"}, 32'(ops_q[0].addr), 32'(addr));
      if (exp_we) chk({tag, "_wdata"}, 32'(ops_q[0].data), 32'(data));
    end
    chk({tag, "_err"}, 32'(errs - e0), 32'(exp_err));
  endtask

  initial begin
    logic [7:0] op, addr, data, rdv;
    int k, dly, e0, n;
    u.rx_byte = 8'h00; u.received = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_transmit", 32'(u.transmit), 0);
    chk("rst_txbyte", 32'(u.tx_byte), 0);
    chk("rst_we_re", 32'({r.reg_we, r.reg_re}), 0);
    chk("rst_addr_wdata", 32'({r.reg_addr, r.reg_wdata}), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(8'h57, 8'h10, 8'hA5, 3, 8'h00, "wr");
    run_frame(8'h52, 8'h22, 8'h00, 2, 8'h3C, "rd");
    run_frame(8'h41, 8'h00, 8'h00, 1, 8'h00, "badop");

    // inter-byte timeout mid-frame
    tx_q.delete(); ops_q.delete(); e0 = errs;
    send_byte(8'h57); send_byte(8'h10);
    repeat (BYTE_TO / 2) @(negedge clk);
    chk("bto_still_busy", 32'(busy), 1);
    wait_idle("bto", 2 * BYTE_TO);
    chk("bto_err", 32'(errs - e0), 1);
    chk("bto_ntx", 32'(tx_q.size()), 0);
    chk("bto_nops", 32'(ops_q.size()), 0);
    run_frame(8'h57, 8'h33, 8'h5A, 4, 8'h00, "after_bto");

    run_frame(8'h52, 8'h44, 8'h00, 0, 8'h00, "bustmo");
    chk("bustmo_wait", 32'(tx_cyc_last - req_cyc >= BUS_TO), 1);

    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 9);
      addr = 8'($urandom); data = 8'($urandom); rdv = 8'($urandom);
      dly = $urandom_range(1, 8);
      if (k < 4) op = M_WR;
      else if (k < 8) op = M_RD;
      else if (k == 8) begin
        op = 8'($urandom);
        while (op == M_WR || op == M_RD) op = 8'($urandom);
      end else begin op = M_RD; dly = 0; end
      run_frame(op, addr, data, dly, rdv, $sformatf("rnd%0d", i));
    end

    // reset while waiting out the data byte
    tx_q.delete(); ops_q.delete(); ack_dly = 2; rd_val = 8'hC3;
    send_byte(8'h52); send_byte(8'h77);
    n = 0;
    while (tx_q.size() < 2 && n < 2000) begin @(negedge clk); n++; end
    chk("rstmid_reach", 32'(tx_q.size()), 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_transmit", 32'(u.transmit), 0);
    chk("rstmid_txbyte", 32'(u.tx_byte), 0);
    chk("rstmid_bus", 32'({r.reg_we, r.reg_re, r.reg_addr, r.reg_wdata}), 0);
    chk("rstmid_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (TXLEN + 2) @(negedge clk);
    run_frame(8'h57, 8'h9E, 8'h61, 3, 8'h00, "after_rst");

    chk("tx_while_busy", 32'(viol_tx), 0);
    chk("bus_stable", 32'(viol_bus), 0);
    chk("ack_to_tx_ge2", 32'(min_lat >= 2), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_dbg_cmd_ctrl.md
Name: uart_dbg_cmd_ctrl

Overview:
Command sequencer between the uart core (9600 baud, 12 MHz) and the debugger's internal register bus. Parses framed read/write commands from received bytes and issues single register-bus transactions. Sequences the uart transmitter to return status and data bytes. Sole owner of the uart transmit and tx_byte inputs.

Parameters:
CLK_FREQ, 12000000, system clock in Hz
BYTE_TIMEOUT_CYC, 120000, max idle cycles between bytes of one frame (10 ms)
BUS_TIMEOUT_CYC, 255, max cycles waiting for reg_ack
ADDR_W, 8, register address width (≤8)

Ports:
iCE_CLK  in  1  system clock
rst_n  in  1  async active-low reset
rx_byte  in  8  byte from uart core
received  in  1  1-cycle strobe, rx_byte valid
is_transmitting  in  1  uart tx busy
tx_byte  out  8  byte to uart core
transmit  out  1  1-cycle transmit strobe
reg_addr  out  ADDR_W  register address
reg_wdata  out  8  write data
reg_we  out  1  1-cycle write strobe
reg_re  out  1  1-cycle read strobe
reg_rdata  in  8  read data, valid with reg_ack
reg_ack  in  1  1-cycle completion strobe
busy  out  1  high in any state other than IDLE
err  out  1  1-cycle pulse on any aborted or NAKed frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; timers cleared. Reset mid-frame or mid-tx discards everything; no response sent.
- Frame: opcode, addr, [data]. 0x57 'W' = write (3 bytes); 0x52 'R' = read (2 bytes). Response: ACK 0x06, then the data byte for reads. Any error → single NAK 0x15.
- States: IDLE → GET_ADDR → (W: GET_DATA) → BUS_REQ → BUS_WAIT → TX_STAT → TX_STAT_WAIT → (R OK: TX_DATA → TX_DATA_WAIT) → IDLE.
- IDLE: on received with a valid opcode, latch it → GET_ADDR. Invalid opcode → TX_STAT with NAK and err pulse.
- GET_ADDR/GET_DATA: capture on received. Byte-gap counter resets on each received. When it reaches BYTE_TIMEOUT_CYC → IDLE silently with err pulse.
- BUS_REQ: one cycle; reg_we or reg_re=1; reg_addr/reg_wdata stable from BUS_REQ through BUS_WAIT exit.
- BUS_WAIT: reg_ack → latch reg_rdata, status=ACK. Counter reaches BUS_TIMEOUT_CYC → status=NAK, err pulse. reg_ack in the same cycle as timeout counts as ACK.
- TX_STAT/TX_DATA: wait until is_transmitting=0, then drive tx_byte and transmit=1 for exactly one cycle.
- *_WAIT: ignore the first cycle after the strobe, then wait for is_transmitting=0.
- Bytes received in any state other than IDLE/GET_ADDR/GET_DATA are dropped. No queueing.
- Write latency: transmit of ACK no earlier than 2 cycles after reg_ack.
- tx_byte holds its value between transmissions.

Optional Feature:
UART_DBG_CSUM_EN
- Defined: each frame carries a trailing checksum byte (8-bit sum of all prior frame bytes, mod 256). A GET_CSUM state precedes BUS_REQ. On mismatch: no bus access, NAK, err pulse. Read responses append a checksum byte (0x06+data mod 256) via TX_CSUM/TX_CSUM_WAIT.
- Undefined: no checksum states; frame formats as above.

Decomposition:
- Package uart_dbg_pkg: opcode constants (OP_WR 0x57, OP_RD 0x52), ACK 0x06, NAK 0x15, state enumeration.
- Sub-module uart_dbg_tx_seq: one-byte transmit handshake (strobe + busy wait), reused for status, data and checksum bytes.

Test Plan:
- Write: rx 0x57,0x10,0xA5 → one reg_we pulse with addr 0x10, data 0xA5; ack after 3 cycles → tx 0x06 only; busy returns to 0.
- Read: rx 0x52,0x22; reg_ack with rdata 0x3C → tx 0x06 then 0x3C, second transmit only after is_transmitting falls.
- Bad opcode 0x41 → tx 0x15, err pulse, no reg_we/reg_re.
- Byte timeout: rx 0x57,0x10, then silence > 120000 cycles → IDLE, err pulse, no tx. A following valid frame works.
- Bus timeout: read with reg_ack never asserted → after 255 cycles tx 0x15, err pulse.
- Reset: assert rst_n=0 mid TX_DATA_WAIT → all outputs 0 immediately. After release, the next frame is processed normally.
